matrix_vector_prod_par: RTL
===========================

// Module: matrix_vector_prod_par
// PURPOSE
//  Parametrised successor to the 4x4 sequential matrix-vector product: computes
//  y = M*v (or M^T*v) for an NxN signed fixed-point matrix using LANES MAC units.
//  Sits between the host-facing input buffer and the result FIFO of the accelerator.
//  Uses valid/ready handshakes on both sides.
//  Adds over the 4x4 block: generic N and width, selectable transpose,
//  rounding/saturation with overflow flag, and back-to-back issue.
// PARAMETERS
//  N      4   matrix dimension (>=2)
//  W      16  element width, signed two's complement
//  FRAC   8   fractional bits of the Q format (0 <= FRAC < W)
//  LANES  1   parallel MACs per cycle; N % LANES == 0 (checked at elaboration)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous reset, active-low
//  i_valid      in   1      input operands valid
//  i_ready      out  1      block can accept operands this cycle
//  i_transpose  in   1      1: compute M^T*v; captured with operands
//  i_matrix     in   N*N*W  M[r][c] at bits [(r*N+c)*W +: W]
//  i_vector     in   N*W    v[c] at bits [c*W +: W]
//  o_product    out  N*W    y[r] at bits [r*W +: W]
//  o_overflow   out  1      one or more y[r] saturated in this result
//  o_valid      out  1      o_product/o_overflow valid
//  o_ready      in   1      downstream accepts result
// BEHAVIOUR
//  Reset (rst=0, any time, async):
//   - state=IDLE; o_valid=0; o_product=0; o_overflow=0.
//   - Accumulators and captured operands cleared.
//   - An in-flight transaction is discarded; no partial result is ever presented.
//  States:
//   IDLE    i_ready=1. On i_valid: capture M, v, i_transpose; go to COMPUTE.
//           Also clear accumulator, step counter and overflow.
//   COMPUTE i_ready=0. i_valid is ignored. One step per cycle; step s covers row
//           r=s/(N/LANES) and columns c=(s%(N/LANES))*LANES .. +LANES-1.
//           Step action: acc += sum over the LANES columns of A[r][c]*v[c], where
//           A = M, or M^T when captured transpose=1.
//           On the last group of a row, y[r] = sat(round(acc)), then acc is cleared.
//           After step S-1 (S=N*N/LANES): go to DONE and set o_valid=1.
//   DONE    o_valid=1. o_product and o_overflow are held stable until o_ready=1.
//           i_ready = o_ready.
//           o_ready & i_valid: result retires and new operands are captured on
//           the same edge; go to COMPUTE.
//           o_ready & !i_valid: o_valid=0; go to IDLE.
//  Latency:
//   - Acceptance edge at T gives o_valid=1 after edge T+S (N=4, LANES=1: 16 cycles).
//   - Throughput is one result per S+1 cycles under back-to-back issue.
//  Arithmetic:
//   - Products are 2W-bit signed. Accumulator is 2W+clog2(N) bits and never wraps.
//   - round: add 2^(FRAC-1) when FRAC>0, then arithmetic shift right by FRAC
//     (round half toward +inf).
//   - sat: clamp to [-2^(W-1), 2^(W-1)-1]. Any clamp sets o_overflow for this result.
//  Boundaries:
//   - Operand ports may change freely after the acceptance edge.
//   - o_product retains the previous result while COMPUTE is running, but o_valid=0.
// TESTING (N=4, W=16, FRAC=8 unless stated; values in Q8.8)
//  1 Identity M, v=[1,2,3,4] -> y=[1,2,3,4], o_overflow=0; o_valid exactly 16
//    cycles after acceptance.
//  2 M[r][c]=r*4+c (plain integers), v=[1,1,1,1], transpose=0 -> [6,22,38,54];
//    transpose=1 -> [24,28,32,36].
//  3 All-100.0 M, v=[100,100,100,100] -> y=[127.996]*4 (0x7FFF), o_overflow=1;
//    next txn: identity -> o_overflow=0.
//  4 Backpressure: hold o_ready=0 for 10 cycles after o_valid -> o_product stable,
//    i_ready=0. Raise o_ready with i_valid=1 -> retire and accept on the same
//    edge, with no gap cycle.
//  5 Reset mid-COMPUTE (step 7): o_valid=0, i_ready=1 after reset release.
//    No stale result; next txn is correct.
//  6 LANES=2 and LANES=4 rebuilds with scenario 2 -> same results at latency 8 and 4.
//    Random M, v vs. a real-valued model: error <= 1 LSB when no saturation.

Source files
------------

// File: rtl/matrix_vector_prod_par_if.sv
// Operand/result handshake bundle for matrix_vector_prod_par.
// The master side drives operands and o_ready; the slave side is the compute block.
interface matrix_vector_prod_par_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
);
  logic             i_valid;
  logic             i_ready;
  logic             i_transpose;
  logic [N*N*W-1:0] i_matrix;
  logic [N*W-1:0]   i_vector;
  logic [N*W-1:0]   o_product;
  logic             o_overflow;
  logic             o_valid;
  logic             o_ready;

  modport master (
    output i_valid, i_transpose, i_matrix, i_vector, o_ready,
    input  i_ready, o_product, o_overflow, o_valid
  );

  modport slave (
    input  i_valid, i_transpose, i_matrix, i_vector, o_ready,
    output i_ready, o_product, o_overflow, o_valid
  );
endinterface

// File: rtl/matrix_vector_prod_par.sv
// NxN signed fixed-point matrix-vector product (optionally transposed) using LANES MACs
// per cycle, with round-half-up, saturation and valid/ready handshakes on both sides.
module matrix_vector_prod_par #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned LANES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  matrix_vector_prod_par_if.slave  io_bus
);

  localparam int unsigned G  = N / LANES;
  localparam int unsigned AW = 2 * W + $clog2(N);
  localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;

  localparam logic signed [AW-1:0] Rnd  = AW'((64'd1 << FRAC) >> 1);
  localparam logic signed [AW-1:0] YMax = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] YMin = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  if ((LANES == 0) || (N < 2) || (FRAC >= W) || ((N % LANES) != 0)) begin : g_param_check
    $error("matrix_vector_prod_par: need N>=2, FRAC<W and N a multiple of LANES");
  end

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e r_state, w_state_d;

  logic [N*N*W-1:0]     r_mat;
  logic [N*W-1:0]       r_vec;
  logic                 r_trans;
  logic signed [AW-1:0] r_acc;
  logic [RW-1:0]        r_row;
  logic [GW-1:0]        r_grp;
  logic [N*W-1:0]       r_res;
  logic [N*W-1:0]       r_prod;
  logic                 r_ovf_wip;
  logic                 r_ovf;

  logic                   w_i_ready;
  logic                   w_accept;
  logic                   w_last_grp;
  logic                   w_last_step;
  logic signed [W-1:0]    w_m [N][N];
  logic signed [W-1:0]    w_v [N];
  logic [RW-1:0]          w_col [LANES];
  logic signed [W-1:0]    w_a [LANES];
  logic signed [2*W-1:0]  w_p [LANES];
  logic signed [AW-1:0]   w_sum;
  logic signed [AW-1:0]   w_acc_sum;
  logic signed [AW-1:0]   w_rnd;
  logic signed [AW-1:0]   w_shift;
  logic                   w_sat;
  logic [W-1:0]           w_y;
  logic [N*W-1:0]         w_res_d;

  always_comb begin
    for (int r = 0; r < N; r++) begin
      w_v[r] = r_vec[r*W +: W];
      for (int c = 0; c < N; c++) begin
        w_m[r][c] = r_mat[(r*N+c)*W +: W];
      end
    end
  end

  // Lane l of group g works on column g*LANES+l; transpose just swaps the indices.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_col[l] = RW'(int'(r_grp) * int'(LANES) + l);
    assign w_a[l]   = r_trans ? w_m[w_col[l]][r_row] : w_m[r_row][w_col[l]];
    assign w_p[l]   = w_a[l] * w_v[w_col[l]];
  end

  always_comb begin
    w_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      w_sum = w_sum + AW'(w_p[l]);
    end
  end

  assign w_acc_sum   = r_acc + w_sum;
  assign w_rnd       = w_acc_sum + Rnd;
  assign w_shift     = w_rnd >>> FRAC;
  assign w_sat       = (w_shift > YMax) || (w_shift < YMin);
  assign w_y         = (w_shift > YMax) ? YMax[W-1:0] :
                       (w_shift < YMin) ? YMin[W-1:0] : w_shift[W-1:0];
  assign w_last_grp  = (r_grp == GW'(G - 1));
  assign w_last_step = w_last_grp && (r_row == RW'(N - 1));
  assign w_accept    = io_bus.i_valid && w_i_ready;

  always_comb begin
    w_res_d = r_res;
    for (int r = 0; r < N; r++) begin
      if (int'(r_row) == r) begin
        w_res_d[r*W +: W] = w_y;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_i_ready = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_i_ready = 1'b1;
        if (io_bus.i_valid) w_state_d = StCompute;
      end
      StCompute: begin
        if (w_last_step) w_state_d = StDone;
      end
      StDone: begin
        w_i_ready = io_bus.o_ready;
        if (io_bus.o_ready) w_state_d = io_bus.i_valid ? StCompute : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mat     <= '0;
      r_vec     <= '0;
      r_trans   <= 1'b0;
      r_acc     <= '0;
      r_row     <= '0;
      r_grp     <= '0;
      r_res     <= '0;
      r_prod    <= '0;
      r_ovf_wip <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_mat     <= io_bus.i_matrix;
      r_vec     <= io_bus.i_vector;
      r_trans   <= io_bus.i_transpose;
      r_acc     <= '0;
      r_row     <= '0;
      r_grp     <= '0;
      r_ovf_wip <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (r_state == StCompute) begin
      if (w_last_grp) begin
        // Rows build up in r_res so o_product keeps the previous result until done.
        r_acc     <= '0;
        r_grp     <= '0;
        r_res     <= w_res_d;
        r_ovf_wip <= r_ovf_wip | w_sat;
        r_row     <= w_last_step ? '0 : r_row + RW'(1);
        if (w_last_step) begin
          r_prod <= w_res_d;
          r_ovf  <= r_ovf_wip | w_sat;
        end
      end else begin
        r_acc <= w_acc_sum;
        r_grp <= r_grp + GW'(1);
      end
    end
  end

  assign io_bus.i_ready    = w_i_ready;
  assign io_bus.o_valid    = (r_state == StDone);
  assign io_bus.o_product  = r_prod;
  assign io_bus.o_overflow = r_ovf;

endmodule
